addr_gen_wr_hc: RTL and testbench
=================================

Name: addr_gen_wr_hc

Overview:
Write address generator for the H and C memories during forward propagation; it is the writer counterpart of the H/C read address generator. Memory layout is NUM_CELL*(TIMESTEP+1) words. Words 0..NUM_CELL-1 hold the zero state for t=-1, and timestep t occupies NUM_CELL*(t+1) onward. The block turns independent C-valid and H-valid strobes from the cell datapath into sequential write addresses and write enables, then signals completion.

Parameters:
ADDR_WIDTH, 12, width of address outputs and internal pointers
TIMESTEP, 7, number of timesteps written
NUM_CELL, 53, LSTM cells per timestep

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (rst=0 resets)
en  input  1  global enable; low freezes the block
i_start  input  1  single-cycle pulse that starts a forward pass
i_valid_c  input  1  new C value present on datapath this cycle
i_valid_h  input  1  new H value present on datapath this cycle
o_addr_c  output  ADDR_WIDTH  C memory write address
o_addr_h  output  ADDR_WIDTH  H memory write address
o_wr_c  output  1  C memory write enable
o_wr_h  output  1  H memory write enable
o_zero  output  1  selects zero write data (clear phase)
o_busy  output  1  high in CLEAR/WRITE
o_done  output  1  one-cycle pulse at pass completion
o_err  output  1  sticky protocol error

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, ptr_c=ptr_h=0.
- All outputs are registered.
- LAST = NUM_CELL*(TIMESTEP+1)-1, computed at ADDR_WIDTH. The integrator guarantees LAST < 2^ADDR_WIDTH.
- en=0, any state: state, pointers and o_err hold. o_wr_c/o_wr_h/o_zero/o_done are driven 0. Valids and i_start are ignored with no error.
- IDLE:
  - i_start=1 & en=1: clear o_err, go to CLEAR (macro defined) or WRITE (macro undefined).
  - Pointers load 0 (CLEAR) or NUM_CELL (WRITE).
- CLEAR (macro only):
  - Each enabled cycle: o_wr_c=o_wr_h=1, o_zero=1, o_addr_c=o_addr_h=ptr, ptr++.
  - After address NUM_CELL-1 is written, go to WRITE with ptr_c=ptr_h=NUM_CELL.
  - Duration: exactly NUM_CELL enabled cycles.
  - Any valid during CLEAR sets o_err and is dropped.
- WRITE: C and H streams are fully independent.
  - Per stream: i_valid_x=1 with ptr_x<=LAST gives, next cycle, o_wr_x=1 and o_addr_x=ptr_x; then ptr_x++. Latency is 1 cycle.
  - Back-to-back valids give consecutive addresses with no bubble.
  - i_valid_x=1 with ptr_x>LAST (stream already finished) sets o_err; the write is dropped.
  - Without a write, o_addr_x holds its last value and o_wr_x=0.
  - When both ptr_c>LAST and ptr_h>LAST, go to DONE, including when both finish on the same cycle.
- DONE: o_done=1 for one cycle, o_busy=0, then IDLE. Valids in DONE set o_err.
- o_busy=1 in CLEAR and WRITE only.
- i_start while not IDLE is ignored, with no effect on pointers or o_err.
- Valids in IDLE are ignored, with no error.
- Reset mid-operation: immediate return to IDLE, no write issued after rst falls. The next pass requires a new i_start.
- Pointers never wrap; they saturate at LAST+1.

Optional Feature:
Macro ADDR_GEN_WR_ZERO_INIT_EN.
- Defined: CLEAR state exists; the t=-1 region is zero-filled by this block before WRITE, and o_zero pulses during that phase.
- Undefined: no CLEAR state; i_start goes directly to WRITE at NUM_CELL. o_zero is tied 0, and the t=-1 region is assumed zeroed by memory initialisation.

Test Plan:
1. NUM_CELL=4, TIMESTEP=2, macro on, i_start, then 8 back-to-back valid_c and valid_h.
   - o_zero/o_wr_c/o_wr_h high 4 cycles at addrs 0,1,2,3.
   - Then writes at 4..11 on both streams, each 1 cycle after its valid.
   - o_done pulses once, then o_busy=0.
2. Same params, valid_h lagging valid_c by 3 cycles, with gaps.
   - o_addr_c and o_addr_h each step 4..11 independently.
   - DONE only after the 8th H write.
3. Same params, 9th valid_c after C finished (H still pending).
   - o_err=1 sticky, no o_wr_c, H still completes and o_done pulses.
   - Next i_start clears o_err.
4. en dropped for 5 cycles mid-WRITE at ptr_c=6, with valids asserted.
   - No writes while en=0, pointer stays 6.
   - After en returns, the next valid_c writes addr 6.
5. rst=0 asserted asynchronously mid-CLEAR at addr 2.
   - All outputs 0 without waiting for clk; stays IDLE after release until i_start.
6. Defaults, macro off, 424-... i.e. 371 valids per stream.
   - First write at addr 53, last at 423, o_zero never asserted.
   - o_done one cycle after the last write.

Source files
------------

// File: rtl/addr_gen_wr_hc.sv
// Write address generator for the H and C memories during LSTM forward propagation.
// Optional macro ADDR_GEN_WR_ZERO_INIT_EN adds a CLEAR phase that zero-fills the t=-1 region.
module addr_gen_wr_hc #(
   parameter int ADDR_WIDTH = 12,
   parameter int TIMESTEP   = 7,
   parameter int NUM_CELL   = 53
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  i_start,
   input  logic                  i_valid_c,
   input  logic                  i_valid_h,
   output logic [ADDR_WIDTH-1:0] o_addr_c,
   output logic [ADDR_WIDTH-1:0] o_addr_h,
   output logic                  o_wr_c,
   output logic                  o_wr_h,
   output logic                  o_zero,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err
);

   // One extra pointer bit keeps the saturation value LAST+1 representable
   // even when LAST occupies the full address range.
   localparam int                    PTR_W  = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(NUM_CELL * (TIMESTEP + 1) - 1);
   localparam logic [PTR_W-1:0]      LAST_P = {1'b0, LAST};
   localparam logic [PTR_W-1:0]      BASE_P = PTR_W'(NUM_CELL);
   localparam logic [PTR_W-1:0]      ONE_P  = PTR_W'(1);
`ifdef ADDR_GEN_WR_ZERO_INIT_EN
   localparam logic [PTR_W-1:0]      CLR_END_P = PTR_W'(NUM_CELL - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [PTR_W-1:0]        ptr_c_q, ptr_c_d;
   logic [PTR_W-1:0]        ptr_h_q, ptr_h_d;
   logic [ADDR_WIDTH-1:0]   addr_c_d, addr_h_d;
   logic                    wr_c_d, wr_h_d;
   logic                    busy_d, done_d, err_d;
`ifdef ADDR_GEN_WR_ZERO_INIT_EN
   logic                    zero_d;
`endif

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state and next-output logic.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      ptr_c_d  = ptr_c_q;
      ptr_h_d  = ptr_h_q;
      addr_c_d = o_addr_c;
      addr_h_d = o_addr_h;
      wr_c_d   = 1'b0;
      wr_h_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = o_err;
`ifdef ADDR_GEN_WR_ZERO_INIT_EN
      zero_d   = 1'b0;
`endif

      if (en) begin
         unique case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  err_d = 1'b0;
`ifdef ADDR_GEN_WR_ZERO_INIT_EN
                  state_d = S_CLEAR;
                  ptr_c_d = '0;
                  ptr_h_d = '0;
`else
                  state_d = S_WRITE;
                  ptr_c_d = BASE_P;
                  ptr_h_d = BASE_P;
`endif
               end
            end

            S_CLEAR: begin
`ifdef ADDR_GEN_WR_ZERO_INIT_EN
               // Both memories are cleared in lockstep from ptr_c.
               wr_c_d   = 1'b1;
               wr_h_d   = 1'b1;
               zero_d   = 1'b1;
               addr_c_d = ptr_c_q[ADDR_WIDTH-1:0];
               addr_h_d = ptr_c_q[ADDR_WIDTH-1:0];
               if (i_valid_c || i_valid_h) err_d = 1'b1;
               if (ptr_c_q == CLR_END_P) begin
                  state_d = S_WRITE;
                  ptr_c_d = BASE_P;
                  ptr_h_d = BASE_P;
               end else begin
                  ptr_c_d = ptr_c_q + ONE_P;
                  ptr_h_d = ptr_c_q + ONE_P;
               end
`else
               state_d = S_IDLE;
`endif
            end

            S_WRITE: begin
               if (i_valid_c) begin
                  if (ptr_c_q <= LAST_P) begin
                     wr_c_d   = 1'b1;
                     addr_c_d = ptr_c_q[ADDR_WIDTH-1:0];
                     ptr_c_d  = ptr_c_q + ONE_P;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               if (i_valid_h) begin
                  if (ptr_h_q <= LAST_P) begin
                     wr_h_d   = 1'b1;
                     addr_h_d = ptr_h_q[ADDR_WIDTH-1:0];
                     ptr_h_d  = ptr_h_q + ONE_P;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               // Uses the updated pointers so a simultaneous final write on
               // both streams still lands in DONE straight away.
               if ((ptr_c_d > LAST_P) && (ptr_h_d > LAST_P)) state_d = S_DONE;
            end

            S_DONE: begin
               done_d  = 1'b1;
               state_d = S_IDLE;
               if (i_valid_c || i_valid_h) err_d = 1'b1;
            end

            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d == S_CLEAR) || (state_d == S_WRITE);
   end

   // Pointers and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_c_q  <= '0;
         ptr_h_q  <= '0;
         o_addr_c <= '0;
         o_addr_h <= '0;
         o_wr_c   <= 1'b0;
         o_wr_h   <= 1'b0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         o_err    <= 1'b0;
      end else begin
         ptr_c_q  <= ptr_c_d;
         ptr_h_q  <= ptr_h_d;
         o_addr_c <= addr_c_d;
         o_addr_h <= addr_h_d;
         o_wr_c   <= wr_c_d;
         o_wr_h   <= wr_h_d;
         o_busy   <= busy_d;
         o_done   <= done_d;
         o_err    <= err_d;
      end
   end

`ifdef ADDR_GEN_WR_ZERO_INIT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) o_zero <= 1'b0;
      else      o_zero <= zero_d;
   end
`else
   assign o_zero = 1'b0;
`endif

endmodule

// File: tb/tb_addr_gen_wr_hc.sv
// Self-checking bench for addr_gen_wr_hc: randomized stimulus against a pass-level reference model.
// Works with or without ADDR_GEN_WR_ZERO_INIT_EN defined.
module tb_addr_gen_wr_hc;

   localparam int AW    = 12;
   localparam int TS    = 2;
   localparam int NC    = 4;
   localparam int TOTAL = NC * TS;   // writes per stream in one pass
`ifdef ADDR_GEN_WR_ZERO_INIT_EN
   localparam bit ZERO_INIT = 1'b1;
`else
   localparam bit ZERO_INIT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          i_start = 1'b0;
   logic          i_valid_c = 1'b0;
   logic          i_valid_h = 1'b0;
   logic [AW-1:0] o_addr_c, o_addr_h;
   logic          o_wr_c, o_wr_h, o_zero, o_busy, o_done, o_err;

   addr_gen_wr_hc #(.ADDR_WIDTH(AW), .TIMESTEP(TS), .NUM_CELL(NC)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .i_start  (i_start),
      .i_valid_c(i_valid_c),
      .i_valid_h(i_valid_h),
      .o_addr_c (o_addr_c),
      .o_addr_h (o_addr_h),
      .o_wr_c   (o_wr_c),
      .o_wr_h   (o_wr_h),
      .o_zero   (o_zero),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_err    (o_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic          wr_c, wr_h, zero, busy, done, err;
      logic [AW-1:0] addr_c, addr_h;
   } obs_t;

   // Reference model: a pass is "start, optional clear of NC words, TOTAL
   // writes per stream at NC.., one done pulse".
   obs_t exp_o;
   bit   m_active, m_done_next;
   int   m_clear_idx, m_cnt_c, m_cnt_h;

   function automatic obs_t observed();
      observed = {o_wr_c, o_wr_h, o_zero, o_busy, o_done, o_err, o_addr_c, o_addr_h};
   endfunction

   function automatic void model_reset();
      exp_o       = '0;
      m_active    = 1'b0;
      m_done_next = 1'b0;
      m_clear_idx = 0;
      m_cnt_c     = 0;
      m_cnt_h     = 0;
   endfunction

   function automatic void model_edge(input bit e, input bit s, input bit vc, input bit vh);
      exp_o.wr_c = 1'b0;
      exp_o.wr_h = 1'b0;
      exp_o.zero = 1'b0;
      exp_o.done = 1'b0;
      if (e) begin
         if (m_done_next) begin
            exp_o.done  = 1'b1;
            m_done_next = 1'b0;
            if (vc || vh) exp_o.err = 1'b1;
         end else if (!m_active) begin
            if (s) begin
               m_active    = 1'b1;
               exp_o.err   = 1'b0;
               m_cnt_c     = 0;
               m_cnt_h     = 0;
               m_clear_idx = ZERO_INIT ? 0 : NC;
            end
         end else if (m_clear_idx < NC) begin
            exp_o.wr_c   = 1'b1;
            exp_o.wr_h   = 1'b1;
            exp_o.zero   = 1'b1;
            exp_o.addr_c = AW'(m_clear_idx);
            exp_o.addr_h = AW'(m_clear_idx);
            m_clear_idx++;
            if (vc || vh) exp_o.err = 1'b1;
         end else begin
            if (vc) begin
               if (m_cnt_c < TOTAL) begin
                  exp_o.wr_c   = 1'b1;
                  exp_o.addr_c = AW'(NC + m_cnt_c);
                  m_cnt_c++;
               end else exp_o.err = 1'b1;
            end
            if (vh) begin
               if (m_cnt_h < TOTAL) begin
                  exp_o.wr_h   = 1'b1;
                  exp_o.addr_h = AW'(NC + m_cnt_h);
                  m_cnt_h++;
               end else exp_o.err = 1'b1;
            end
            if (m_cnt_c == TOTAL && m_cnt_h == TOTAL) begin
               m_active    = 1'b0;
               m_done_next = 1'b1;
            end
         end
      end
      exp_o.busy = m_active;
   endfunction

   task automatic drive(input bit e, input bit s, input bit vc, input bit vh);
      en        = e;
      i_start   = s;
      i_valid_c = vc;
      i_valid_h = vh;
      @(posedge clk);
      #1;
      model_edge(e, s, vc, vh);
   endtask

   task automatic start_pass(input string tag);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      if (observed() !== exp_o) begin
         n_fail++;
         $display("FAIL %s_start: got %h want %h", tag, observed(), exp_o);
      end
      n_tests++;
      for (int k = 0; k < NC && m_active && m_clear_idx < NC; k++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         if (observed() !== exp_o) begin
            n_fail++;
            $display("FAIL %s_clear%0d: got %h want %h", tag, k, observed(), exp_o);
         end
         n_tests++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      en = 1'b1;
      i_start = 1'b1;
      i_valid_c = 1'b1;
      i_valid_h = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      if (observed() !== exp_o) begin
         n_fail++;
         $display("FAIL reset_hold: got %h want %h", observed(), exp_o);
      end
      n_tests++;
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 1'b1);   // valids in IDLE: no write, no error
      if (observed() !== exp_o) begin
         n_fail++;
         $display("FAIL reset_idle_valids: got %h want %h", observed(), exp_o);
      end
      n_tests++;
   endtask

   task automatic test_back_to_back();
      int done_seen = 0;
      start_pass("b2b");
      for (int c = 0; c < TOTAL + 3; c++) begin
         drive(1'b1, 1'b0, c < TOTAL, c < TOTAL);
         if (observed() !== exp_o) begin
            n_fail++;
            $display("FAIL b2b_cyc%0d: got %h want %h", c, observed(), exp_o);
         end
         n_tests++;
         done_seen += int'(o_done);
      end
      if (done_seen !== 1) begin
         n_fail++;
         $display("FAIL b2b_done_count: got %0d want 1", done_seen);
      end
      n_tests++;
   endtask

   task automatic test_lag();
      int       done_seen = 0;
      int       sent_c = 0;
      logic [2:0] sr = '0;
      bit       vc, vh;
      start_pass("lag");
      for (int c = 0; c < 300; c++) begin
         vc = (sent_c < TOTAL) && ($urandom_range(99) < 60);
         sent_c += int'(vc);
         vh = sr[2];
         sr = {sr[1:0], vc};
         drive(1'b1, 1'b0, vc, vh);
         if (observed() !== exp_o) begin
            n_fail++;
            $display("FAIL lag_cyc%0d: got %h want %h", c, observed(), exp_o);
         end
         n_tests++;
         done_seen += int'(o_done);
         if (exp_o.done) break;
      end
      if (done_seen !== 1) begin
         n_fail++;
         $display("FAIL lag_done_count: got %0d want 1", done_seen);
      end
      n_tests++;
   endtask

   task automatic test_overrun();
      int done_seen = 0;
      int sent_h = 0;
      bit vh;
      start_pass("ovr");
      for (int c = 0; c < 80; c++) begin
         vh = (c % 2 == 0) && (sent_h < TOTAL);
         sent_h += int'(vh);
         drive(1'b1, 1'b0, c < TOTAL + 1, vh);
         if (observed() !== exp_o) begin
            n_fail++;
            $display("FAIL ovr_cyc%0d: got %h want %h", c, observed(), exp_o);
         end
         n_tests++;
         done_seen += int'(o_done);
         if (exp_o.done) break;
      end
      if (o_err !== 1'b1 || done_seen !== 1) begin
         n_fail++;
         $display("FAIL ovr_err_done: got err=%b done=%0d want err=1 done=1", o_err, done_seen);
      end
      n_tests++;
      start_pass("ovr_restart");   // new start must clear o_err
      for (int c = 0; c < TOTAL + 2; c++) begin
         drive(1'b1, 1'b0, c < TOTAL, c < TOTAL);
         if (observed() !== exp_o) begin
            n_fail++;
            $display("FAIL ovr_restart_cyc%0d: got %h want %h", c, observed(), exp_o);
         end
         n_tests++;
      end
   endtask

   task automatic test_enable_hold();
      start_pass("en");
      for (int c = 0; c < 10 && m_cnt_c < 2; c++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b1);
         if (observed() !== exp_o) begin
            n_fail++;
            $display("FAIL en_pre%0d: got %h want %h", c, observed(), exp_o);
         end
         n_tests++;
      end
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b1);
         if (observed() !== exp_o) begin
            n_fail++;
            $display("FAIL en_low%0d: got %h want %h", c, observed(), exp_o);
         end
         n_tests++;
      end
      for (int c = 0; c < TOTAL + 2; c++) begin
         drive(1'b1, 1'b0, 1'b1, c < 3);
         if (observed() !== exp_o) begin
            n_fail++;
            $display("FAIL en_post%0d: got %h want %h", c, observed(), exp_o);
         end
         n_tests++;
      end
      for (int c = 0; c < TOTAL + 3 && (m_active || m_done_next); c++) begin
         drive(1'b1, 1'b0, 1'b0, m_cnt_h < TOTAL);
         if (observed() !== exp_o) begin
            n_fail++;
            $display("FAIL en_tail%0d: got %h want %h", c, observed(), exp_o);
         end
         n_tests++;
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 1'b0, !ZERO_INIT, !ZERO_INIT);
         if (observed() !== exp_o) begin
            n_fail++;
            $display("FAIL arst_pre%0d: got %h want %h", c, observed(), exp_o);
         end
         n_tests++;
      end
      #2 rst = 1'b0;   // between clock edges
      #1;
      model_reset();
      if (observed() !== exp_o) begin
         n_fail++;
         $display("FAIL arst_immediate: got %h want %h", observed(), exp_o);
      end
      n_tests++;
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b1);
         if (observed() !== exp_o) begin
            n_fail++;
            $display("FAIL arst_idle%0d: got %h want %h", c, observed(), exp_o);
         end
         n_tests++;
      end
   endtask

   task automatic test_random();
      bit e, s, vc, vh;
      for (int c = 0; c < 1500; c++) begin
         e  = $urandom_range(99) < 85;
         s  = $urandom_range(99) < 4;
         vc = $urandom_range(99) < 50;
         vh = $urandom_range(99) < 50;
         drive(e, s, vc, vh);
         if (observed() !== exp_o) begin
            n_fail++;
            $display("FAIL rand_cyc%0d: got %h want %h", c, observed(), exp_o);
         end
         n_tests++;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_lag();
      test_overrun();
      test_enable_hold();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
